// File: rtl/multicycle_control.sv
// Purpose : multi-cycle sequencer for lw/sw/R-type/addi/bne over a shared datapath.
// Latency : lw 5, sw 4, R/addi 4, bne 3 cycles, +1 per memory wait cycle.
// Backpr. : FETCH/MEM hold on !memReady and halt with fault after TIMEOUT_CYCLES waits.
//
// Ports:
//   clk, reset_n         clock and async active-low reset (all outputs 0 while low)
//   opcode               instr[6:0] from IR, valid from DECODE onward
//   zero                 ALU zero flag, used by bne in EXEC
//   memReady             completes the current memory request cycle
//   memReq/memWe         memory request and write enable (sw)
//   memAddrSel           memory address mux: 0=PC, 1=aluOut
//   irWrite/pcWrite      load IR+oldPC / load PC (pcWrite already zero-qualified for bne)
//   pcSrc                PC source: 0=ALU result, 1=aluOut
//   aluSrcA/aluSrcB      ALU operand muxes
//   aluOp                00=add, 01=sub/compare, 10=funct-decoded
//   regWrite/memToReg    register writeback strobe and source select
//   halted/illegal/fault HALT state flag and sticky halt causes
//   instrCount           retired-instruction counter, wraps
module multicycle_control #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             memReady,
  output logic             memReq,
  output logic             memWe,
  output logic             memAddrSel,
  output logic             irWrite,
  output logic             pcWrite,
  output logic             pcSrc,
  output logic [1:0]       aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       aluOp,
  output logic             regWrite,
  output logic             memToReg,
  output logic             halted,
  output logic             illegal,
  output logic             fault,
  output logic [CNT_W-1:0] instrCount
);

  // Supported opcodes
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BNE  = 7'b1100011;

  // Mux encodings
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  // Wait counter only needs to reach TIMEOUT_CYCLES; it saturates there.
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t             state;
  state_t             stateNext;
  logic [6:0]         opReg;
  logic [WAIT_W-1:0]  waitCnt;
  logic               memStall;
  logic               timeoutHit;
  logic               retire;
  logic               legalOp;
  logic               setIllegal;
  logic               setFault;
  logic               illegalReg;
  logic               faultReg;

  // Raw decoded outputs, before reset gating
  logic       memReqRaw;
  logic       memWeRaw;
  logic       memAddrSelRaw;
  logic       irWriteRaw;
  logic       pcWriteRaw;
  logic       pcSrcRaw;
  logic [1:0] aluSrcARaw;
  logic [1:0] aluSrcBRaw;
  logic [1:0] aluOpRaw;
  logic       regWriteRaw;
  logic       memToRegRaw;
  logic       haltedRaw;

  assign legalOp = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_R) ||
                   (opcode == OP_ADDI) || (opcode == OP_BNE);

  // A stall is any cycle that requests memory without completion.
  assign memStall   = ((state == FETCH) || (state == MEM)) && !memReady;
  // memReady in the limit cycle wins because memStall is then false.
  assign timeoutHit = (TIMEOUT_CYCLES != 0) && memStall && (waitCnt == WAIT_MAX);

  // Every path back into FETCH from another state completes an instruction.
  assign retire = (stateNext == FETCH) && (state != FETCH);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
    end else begin
      state <= stateNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext  = state;
    setIllegal = 1'b0;
    setFault   = 1'b0;
    case (state)
      FETCH: begin
        if (memReady) begin
          stateNext = DECODE;
        end else if (timeoutHit) begin
          stateNext = HALT;
          setFault  = 1'b1;
        end
      end
      DECODE: begin
        if (legalOp) begin
          stateNext = EXEC;
        end else begin
          stateNext  = HALT;
          setIllegal = 1'b1;
        end
      end
      EXEC: begin
        case (opReg)
          OP_LW, OP_SW:  stateNext = MEM;
          OP_R, OP_ADDI: stateNext = WB;
          OP_BNE:        stateNext = FETCH;
          // opReg only ever holds a legal opcode here; park safely otherwise.
          default:       stateNext = HALT;
        endcase
      end
      MEM: begin
        if (memReady) begin
          stateNext = (opReg == OP_SW) ? FETCH : WB;
        end else if (timeoutHit) begin
          stateNext = HALT;
          setFault  = 1'b1;
        end
      end
      WB:      stateNext = FETCH;
      HALT:    stateNext = HALT;
      default: stateNext = HALT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    memReqRaw     = 1'b0;
    memWeRaw      = 1'b0;
    memAddrSelRaw = 1'b0;
    irWriteRaw    = 1'b0;
    pcWriteRaw    = 1'b0;
    pcSrcRaw      = 1'b0;
    aluSrcARaw    = SRCA_PC;
    aluSrcBRaw    = SRCB_RS2;
    aluOpRaw      = ALU_ADD;
    regWriteRaw   = 1'b0;
    memToRegRaw   = 1'b0;
    haltedRaw     = 1'b0;
    case (state)
      FETCH: begin
        // PC+4 is computed in the same cycle the instruction word arrives.
        memReqRaw  = 1'b1;
        aluSrcARaw = SRCA_PC;
        aluSrcBRaw = SRCB_FOUR;
        aluOpRaw   = ALU_ADD;
        irWriteRaw = memReady;
        pcWriteRaw = memReady;
      end
      DECODE: begin
        // Speculative branch target oldPC+imm lands in aluOut.
        aluSrcARaw = SRCA_OLDPC;
        aluSrcBRaw = SRCB_IMM;
        aluOpRaw   = ALU_ADD;
      end
      EXEC: begin
        aluSrcARaw = SRCA_RS1;
        case (opReg)
          OP_LW, OP_SW, OP_ADDI: begin
            aluSrcBRaw = SRCB_IMM;
            aluOpRaw   = ALU_ADD;
          end
          OP_R: begin
            aluSrcBRaw = SRCB_RS2;
            aluOpRaw   = ALU_FUNCT;
          end
          OP_BNE: begin
            aluSrcBRaw = SRCB_RS2;
            aluOpRaw   = ALU_SUB;
            pcSrcRaw   = 1'b1;
            pcWriteRaw = !zero;
          end
          default: begin
            aluSrcARaw = SRCA_PC;
          end
        endcase
      end
      MEM: begin
        memReqRaw     = 1'b1;
        memAddrSelRaw = 1'b1;
        memWeRaw      = (opReg == OP_SW);
      end
      WB: begin
        regWriteRaw = 1'b1;
        memToRegRaw = (opReg == OP_LW);
      end
      HALT: begin
        haltedRaw = 1'b1;
      end
      default: begin
        haltedRaw = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath-side registers: opcode latch, wait counter, sticky flags, counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opReg <= 7'd0;
    end else if (state == DECODE) begin
      opReg <= opcode;
    end
  end

  // Any state change clears the counter, which covers entry to FETCH and MEM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      waitCnt <= '0;
    end else if (stateNext != state) begin
      waitCnt <= '0;
    end else if (memStall && (waitCnt != WAIT_MAX)) begin
      waitCnt <= waitCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegalReg <= 1'b0;
      faultReg   <= 1'b0;
    end else begin
      if (setIllegal) illegalReg <= 1'b1;
      if (setFault)   faultReg   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instrCount <= '0;
    end else if (retire) begin
      instrCount <= instrCount + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Reset gating: decoded outputs drop to 0 as soon as reset_n falls, without
  // waiting for a clock edge (state itself is already FETCH at that point).
  // ---------------------------------------------------------------------------
  assign memReq     = memReqRaw     & reset_n;
  assign memWe      = memWeRaw      & reset_n;
  assign memAddrSel = memAddrSelRaw & reset_n;
  assign irWrite    = irWriteRaw    & reset_n;
  assign pcWrite    = pcWriteRaw    & reset_n;
  assign pcSrc      = pcSrcRaw      & reset_n;
  assign aluSrcA    = reset_n ? aluSrcARaw : 2'b00;
  assign aluSrcB    = reset_n ? aluSrcBRaw : 2'b00;
  assign aluOp      = reset_n ? aluOpRaw   : 2'b00;
  assign regWrite   = regWriteRaw   & reset_n;
  assign memToReg   = memToRegRaw   & reset_n;
  assign halted     = haltedRaw     & reset_n;
  assign illegal    = illegalReg    & reset_n;
  assign fault      = faultReg      & reset_n;

endmodule

// File: tb/tb_multicycle_control.sv
// Purpose : randomized check of multicycle_control against an instruction-level model.
// Latency : expected per-cycle strobes are generated phase by phase from each instruction.
// Backpr. : memReady stall counts are chosen per instruction, including timeout limits.
module tb_multicycle_control;

  localparam int TO    = 4;
  localparam int CNT_W = 4;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BNE  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic             clk;
  logic             reset_n;
  logic [6:0]       opcode;
  logic             zero;
  logic             memReady;
  logic             memReq;
  logic             memWe;
  logic             memAddrSel;
  logic             irWrite;
  logic             pcWrite;
  logic             pcSrc;
  logic [1:0]       aluSrcA;
  logic [1:0]       aluSrcB;
  logic [1:0]       aluOp;
  logic             regWrite;
  logic             memToReg;
  logic             halted;
  logic             illegal;
  logic             fault;
  logic [CNT_W-1:0] instrCount;

  logic [16:0] outVec;
  int nChecks;
  int nFail;
  int modelCount;

  multicycle_control #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .memReady(memReady),
    .memReq(memReq), .memWe(memWe), .memAddrSel(memAddrSel), .irWrite(irWrite),
    .pcWrite(pcWrite), .pcSrc(pcSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .aluOp(aluOp), .regWrite(regWrite), .memToReg(memToReg), .halted(halted),
    .illegal(illegal), .fault(fault), .instrCount(instrCount)
  );

  assign outVec = {memReq, memWe, memAddrSel, irWrite, pcWrite, pcSrc,
                   aluSrcA, aluSrcB, aluOp, regWrite, memToReg, halted, illegal, fault};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] mk(input logic mReq, mWe, aSel, irW, pcW, pSrc,
                                     input logic [1:0] sA, sB, op,
                                     input logic rW, m2r, hlt, ill, flt);
    return {mReq, mWe, aSel, irW, pcW, pSrc, sA, sB, op, rW, m2r, hlt, ill, flt};
  endfunction

  function automatic logic isLegal(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_ADDI) || (op == OP_BNE);
  endfunction

  // One clock cycle: drive inputs just after the rising edge, check at the falling edge.
  task automatic cyc(input logic rdy, input logic [6:0] op, input logic z,
                     input logic [16:0] expRec, input string tag);
    memReady = rdy;
    opcode   = op;
    zero     = z;
    @(negedge clk);
    checkVal(tag, 32'(outVec), 32'(expRec));
    checkVal({tag, "Cnt"}, 32'(instrCount), 32'(modelCount % (1 << CNT_W)));
    @(posedge clk);
    #1;
  endtask

  task automatic haltCycles(input logic ill, input logic flt, input int n);
    for (int i = 0; i < n; i++)
      cyc(1'($urandom), 7'($urandom), 1'($urandom),
          mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, ill, flt), "halt");
  endtask

  // One instruction: fs / ms are memReady-low cycles before completion in FETCH / MEM.
  // More than TO stalls means the access times out.
  task automatic runInstr(input logic [6:0] op, input logic z, input int fs, input int ms);
    logic r;
    for (int i = 0; i <= fs; i++) begin
      if (i > TO) begin
        haltCycles(0, 1, 6);
        return;
      end
      r = (i == fs);
      cyc(r, 7'($urandom), 1'($urandom),
          mk(1, 0, 0, r, r, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 0), "fetch");
    end
    cyc(1'($urandom), op, 1'($urandom),
        mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 0), "decode");
    if (!isLegal(op)) begin
      haltCycles(1, 0, 20);
      return;
    end
    // Opcode input is scrambled from here on; the latched opcode must rule.
    case (op)
      OP_LW, OP_SW, OP_ADDI:
        cyc(1'($urandom), 7'($urandom), 1'($urandom),
            mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 0, 0, 0, 0, 0), "execImm");
      OP_R:
        cyc(1'($urandom), 7'($urandom), 1'($urandom),
            mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, 0, 0, 0, 0), "execR");
      default: begin
        cyc(1'($urandom), 7'($urandom), z,
            mk(0, 0, 0, 0, !z, 1, 2'b10, 2'b00, 2'b01, 0, 0, 0, 0, 0), "execBne");
        modelCount++;
        return;
      end
    endcase
    if (op == OP_LW || op == OP_SW) begin
      for (int i = 0; i <= ms; i++) begin
        if (i > TO) begin
          haltCycles(0, 1, 6);
          return;
        end
        r = (i == ms);
        cyc(r, 7'($urandom), 1'($urandom),
            mk(1, op == OP_SW, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0), "mem");
      end
      if (op == OP_SW) begin
        modelCount++;
        return;
      end
    end
    cyc(1'($urandom), 7'($urandom), 1'($urandom),
        mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, op == OP_LW, 0, 0, 0), "wb");
    modelCount++;
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    #1;
    modelCount = 0;
    checkVal("rstOut", 32'(outVec), 32'd0);
    checkVal("rstCnt", 32'(instrCount), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [6:0] ops [5];
    logic [6:0] badOp;
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R; ops[3] = OP_ADDI; ops[4] = OP_BNE;
    nChecks    = 0;
    nFail      = 0;
    modelCount = 0;
    reset_n    = 1'b0;
    opcode     = 7'd0;
    zero       = 1'b0;
    memReady   = 1'b0;
    @(posedge clk);
    #1;
    applyReset();

    // Directed: basic latencies, sw wait states, both bne outcomes.
    runInstr(OP_LW, 0, 0, 0);
    runInstr(OP_SW, 0, 0, 3);
    runInstr(OP_BNE, 0, 0, 0);
    runInstr(OP_BNE, 1, 0, 0);
    runInstr(OP_R, 0, 1, 0);
    runInstr(OP_ADDI, 0, 0, 0);
    // memReady arriving in the limit cycle must still complete normally.
    runInstr(OP_LW, 0, TO, TO);
    runInstr(OP_SW, 0, TO, TO);

    // Random legal traffic; enough retires to wrap the counter several times.
    for (int n = 0; n < 150; n++)
      runInstr(ops[$urandom_range(0, 4)], 1'($urandom),
               $urandom_range(0, TO), $urandom_range(0, TO));

    // Illegal opcodes halt after DECODE and stay halted.
    runInstr(OP_JAL, 0, 0, 0);
    applyReset();
    do badOp = 7'($urandom); while (isLegal(badOp));
    runInstr(OP_ADDI, 0, 0, 0);
    runInstr(badOp, 0, 0, 0);
    applyReset();

    // Memory timeouts in FETCH and in MEM.
    runInstr(OP_LW, 0, TO + 1, 0);
    applyReset();
    runInstr(OP_ADDI, 0, 0, 0);
    runInstr(OP_SW, 0, 0, TO + 1);
    applyReset();

    // Reset in the middle of a lw MEM phase aborts it without retiring.
    runInstr(OP_ADDI, 0, 0, 0);
    runInstr(OP_R, 0, 0, 0);
    cyc(1, 7'($urandom), 0, mk(1, 0, 0, 1, 1, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 0), "abFetch");
    cyc(1, OP_LW, 0, mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 0), "abDecode");
    cyc(1, 7'($urandom), 0, mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 0, 0, 0, 0, 0), "abExec");
    memReady = 1'b0;
    @(negedge clk);
    checkVal("abMem", 32'(outVec), 32'(mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0)));
    #2;
    reset_n = 1'b0;
    #1;
    modelCount = 0;
    checkVal("abortOut", 32'(outVec), 32'd0);
    checkVal("abortCnt", 32'(instrCount), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    runInstr(OP_LW, 0, 0, 0);
    runInstr(OP_BNE, 0, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
